// File: rtl/mult8_seq4_ctrl.sv
// mult8_seq4_ctrl
//   Sequential 8x8 unsigned multiplier controller. It does no multiplying of
//   its own: it time-multiplexes an external combinational 4x4 multiplier over
//   four RUN cycles and accumulates the shifted partial products into a 16-bit
//   result.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair offered
//   in_ready   block can accept a pair (IDLE only, decoded from state)
//   A, B       8-bit multiplicand / multiplier, latched on accept
//   mult_a/b   4-bit slices driven to the external 4x4 multiplier (0 outside RUN)
//   mult_p     8-bit combinational product from the external multiplier
//   out_valid  P holds a completed product
//   out_ready  consumer accepts P
//   P          16-bit product, held until out_ready is sampled high in DONE
//   err        sticky self-check failure flag
//
// Build option
//   MULT8_SEQ_SELFCHECK_EN  when defined, A*B is registered on accept and
//                           compared with the accumulated result on DONE
//                           entry; a difference sets err until reset. When
//                           undefined, err is tied to 0 and no 8x8 multiply
//                           is built.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | step 0..3 drives one slice pair and accumulates its partial product
// DONE  | out_valid=1, P stable until out_ready

module mult8_seq4_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [3:0]  mult_a,
  output logic [3:0]  mult_b,
  input  logic [7:0]  mult_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] p_q, p_d;
  logic        out_valid_q, out_valid_d;

  logic        accept;
  logic        done_entry;
  logic [15:0] prod_ext;
  logic [15:0] addend;
  logic [15:0] acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      acc_q       <= 16'h0000;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      p_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Slice selection and partial-product alignment. Steps 1 and 2 are the two
  // cross terms and share the same 4-bit weight.
  always_comb begin
    mult_a   = 4'h0;
    mult_b   = 4'h0;
    prod_ext = {8'h00, mult_p};
    addend   = 16'h0000;
    if (state_q == S_RUN) begin
      case (step_q)
        2'd0: begin
          mult_a = a_q[3:0];
          mult_b = b_q[3:0];
          addend = prod_ext;
        end
        2'd1: begin
          mult_a = a_q[3:0];
          mult_b = b_q[7:4];
          addend = prod_ext << 4;
        end
        2'd2: begin
          mult_a = a_q[7:4];
          mult_b = b_q[3:0];
          addend = prod_ext << 4;
        end
        default: begin
          mult_a = a_q[7:4];
          mult_b = b_q[7:4];
          addend = prod_ext << 8;
        end
      endcase
    end
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    done_entry  = 1'b0;

    in_ready = (state_q == S_IDLE);
    accept   = in_valid & in_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        if (step_q == 2'd3) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          p_d         = acc_sum;
          done_entry  = 1'b1;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign P         = p_q;

`ifdef MULT8_SEQ_SELFCHECK_EN
  logic [15:0] exp_q, exp_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 16'h0000;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (accept) begin
      exp_d = A * B;
    end
    if (done_entry && (acc_sum != exp_q)) begin
      err_d = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult8_seq4_ctrl.sv
module tb_mult8_seq4_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  mult_a;
  logic [3:0]  mult_b;
  logic [7:0]  mult_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
  logic        err;
  logic        zero_p;

  int total;
  int bad;

  mult8_seq4_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .err       (err)
  );

  // External 4x4 multiplier model, with a hook to corrupt its product.
  assign mult_p = zero_p ? 8'h00 : ({4'h0, mult_a} * {4'h0, mult_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          stall;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operand pair from IDLE through the DONE handshake. Checks the
  // slice sequence, the 4-edge latency, P stability while stalled and the
  // return to IDLE. Called and returns at a negedge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input int stall);
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    ea[0] = a[3:0]; eb[0] = b[3:0];
    ea[1] = a[3:0]; eb[1] = b[7:4];
    ea[2] = a[7:4]; eb[2] = b[3:0];
    ea[3] = a[7:4]; eb[3] = b[7:4];
    chk("idle_in_ready", in_ready, 1);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = a ^ b ^ 8'h5A;
    for (int s = 0; s < 4; s++) begin
      chk("run_mult_a", mult_a, ea[s]);
      chk("run_mult_b", mult_b, eb[s]);
      chk("run_no_valid", {out_valid, in_ready}, 0);
      @(negedge clk);
    end
    chk("done_valid", out_valid, 1);
    chk("done_p", P, p);
    chk("done_mult_zero", {mult_a, mult_b}, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_p", P, p);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle_ready", in_ready, 1);
    chk("back_idle_valid", out_valid, 0);
    chk("idle_p_hold", P, p);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 8'h00; B = 8'h00; zero_p = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 16'h0000, 0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
    vecs[2] = '{8'h12, 8'h34, 16'h03A8, 5};
    vecs[3] = '{8'hAB, 8'hCD, 16'h88EF, 1};
    vecs[4] = '{8'h80, 8'h02, 16'h0100, 0};
    vecs[5] = '{8'h0F, 8'hF0, 16'h0E10, 2};
    vecs[6] = '{8'hF0, 8'h0F, 16'h0E10, 0};
    vecs[7] = '{8'h01, 8'hFF, 16'h00FF, 3};

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", P, 16'h0000);
    chk("rst_err", err, 0);
    chk("rst_mult", {mult_a, mult_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].stall);
      chk("vec_err", err, 0);
    end

    // Back-to-back with in_valid held high: second accept only after IDLE.
    A = 8'h12; B = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    A = 8'hAB; B = 8'hCD;
    repeat (3) @(negedge clk);
    chk("b2b_not_yet", out_valid, 0);
    @(negedge clk);
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_p", P, 16'h03A8);
    chk("b2b_first_in_ready", in_ready, 0);
    @(negedge clk);
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_idle_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accepted", in_ready, 0);
    chk("b2b_second_step0", {mult_a, mult_b}, 8'hBD);
    repeat (3) @(negedge clk);
    chk("b2b_second_not_yet", out_valid, 0);
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_p", P, 16'h88EF);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_end_idle", in_ready, 1);

    // Reset in RUN step 2 discards the product.
    A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rrun_step2_slice", {mult_a, mult_b}, 8'hFF);
    rst = 1'b1;
    #1;
    chk("rrun_in_ready", in_ready, 1);
    chk("rrun_out_valid", out_valid, 0);
    chk("rrun_p", P, 16'h0000);
    chk("rrun_mult", {mult_a, mult_b}, 0);
    chk("rrun_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rrun_no_valid", out_valid, 0);
    end
    run_op(8'h02, 8'h03, 16'h0006, 0);

`ifdef MULT8_SEQ_SELFCHECK_EN
    // Corrupt the step-1 partial product: err must latch on DONE entry.
    A = 8'h12; B = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    zero_p = 1'b1;
    @(negedge clk);
    zero_p = 1'b0;
    chk("sc_err_before_done", err, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sc_valid", out_valid, 1);
    chk("sc_p_corrupt", P, 16'h0348);
    chk("sc_err_set", err, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run_op(8'h02, 8'h03, 16'h0006, 0);
    chk("sc_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    chk("sc_err_cleared", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
